// File: rtl/accum_col.sv
`default_nettype none
// ============================================================================
// Module   : accum_col
// Brief    : Column accumulator for a MAC array with saturating RMW entries
//            and a handshaked drain of all entries.
// Revision : 1.0
// ============================================================================
module accum_col #(
  parameter  int DEPTH = 8,
  parameter  int ACC_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  input  logic [23:0]      i_in_data,
  input  logic [AW-1:0]    i_in_addr,
  input  logic             i_acc_en,
  input  logic             i_drain_start,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_out_data,
  output logic [AW-1:0]    o_out_addr,
  output logic             o_busy,
  output logic             o_sat_flag,
  output logic             o_drop_flag
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_entries [DEPTH];
  logic [AW-1:0]    r_ptr;
  logic             r_sat;
  logic             r_drop;

  logic [ACC_W-1:0] w_cur;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_upd;
  logic             w_hs;
  logic             w_wr;

  // Read-modify-write uses the registered entry, so a write on the previous
  // edge is already visible to a back-to-back update of the same address.
  assign w_cur = r_entries[i_in_addr];
  assign w_ext = ACC_W'(i_in_data);
  assign w_sum = {1'b0, w_cur} + {1'b0, w_ext};
  assign w_ovf = w_sum[ACC_W];
  assign w_upd = !i_acc_en ? w_ext : (w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0]);
  assign w_wr  = (r_state == S_IDLE) && i_in_valid;
  assign w_hs  = (r_state == S_DRAIN) && i_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    o_out_addr  = '0;
    o_out_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (i_drain_start) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        o_out_addr  = r_ptr;
        o_out_data  = r_entries[r_ptr];
        if (i_out_ready && (r_ptr == AW'(DEPTH - 1))) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else if (w_wr) begin
      r_entries[i_in_addr] <= w_upd;
    end else if (w_hs) begin
      r_entries[r_ptr] <= '0;
    end
  end

  // DEPTH is a power of two, so the pointer wraps to 0 on the last handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_wr && i_acc_en && w_ovf) begin
        r_sat <= 1'b1;
      end
      if ((r_state == S_DRAIN) && i_in_valid) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign o_sat_flag  = r_sat;
  assign o_drop_flag = r_drop;

endmodule
`default_nettype wire

// File: doc/accum_col.md
ACCUM_COL -- requirements
Module: accum_col

Interface
REQ-001 Parameter DEPTH, default 8, number of accumulator entries (power of 2, >=2).
REQ-002 Parameter ACC_W, default 32, accumulator entry width in bits (>=24).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  column result from bottom MAC of array present this cycle.
REQ-006 in_data  input  24  unsigned 24-bit MAC column output.
REQ-007 in_addr  input  log2(DEPTH)  target entry index.
REQ-008 acc_en  input  1  1 = add in_data to entry; 0 = overwrite entry with in_data.
REQ-009 drain_start  input  1  request to stream all entries out.
REQ-010 out_valid  output  1  out_data/out_addr valid.
REQ-011 out_ready  input  1  consumer accepts current output.
REQ-012 out_data  output  ACC_W  entry value being drained.
REQ-013 out_addr  output  log2(DEPTH)  index of entry being drained.
REQ-014 busy  output  1  high while in DRAIN.
REQ-015 sat_flag  output  1  sticky: an accumulation saturated.
REQ-016 drop_flag  output  1  sticky: an in_valid was dropped during DRAIN.

Function
REQ-017 The block SHALL hold DEPTH unsigned ACC_W-bit entries in registers and implement a two-state FSM: IDLE, DRAIN.
REQ-018 In IDLE, in_valid=1 SHALL update entry in_addr at the same edge: acc_en=1 -> entry+zero-extended in_data; acc_en=0 -> zero-extended in_data.
REQ-019 Accumulation SHALL saturate at 2^ACC_W-1; a saturating add SHALL set sat_flag, which stays 1 until reset.
REQ-020 Back-to-back in_valid to the same in_addr on consecutive cycles SHALL each see the previous cycle's result (no lost updates, 1-cycle read-modify-write).
REQ-021 In IDLE, drain_start=1 SHALL move the FSM to DRAIN at that edge; an in_valid in the same cycle SHALL still be applied and be visible in the drained data.
REQ-022 In DRAIN, out_valid SHALL be 1, busy SHALL be 1, out_addr SHALL equal the drain pointer (starting at 0), out_data SHALL equal the current entry at out_addr.
REQ-023 out_data and out_addr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 On out_valid&out_ready, the entry at out_addr SHALL be cleared to 0 and the pointer SHALL increment; after the handshake at out_addr=DEPTH-1 the FSM SHALL return to IDLE next cycle with out_valid=0 and pointer=0.
REQ-025 First out_valid SHALL occur the cycle after drain_start is sampled; with out_ready held 1 a drain SHALL take exactly DEPTH cycles.
REQ-026 In DRAIN, in_valid SHALL be ignored (no entry change) and SHALL set drop_flag; drain_start SHALL be ignored.
REQ-027 In IDLE, out_valid SHALL be 0, busy 0, out_addr 0; out_data SHALL be 0.

Reset
REQ-028 rst=1 at an edge SHALL, regardless of state (including mid-drain), set FSM to IDLE, all entries to 0, pointer to 0, out_valid 0, busy 0, sat_flag 0, drop_flag 0.
REQ-029 rst SHALL take priority over in_valid, drain_start and out_ready in the same cycle.

Verification
REQ-030 Overwrite then accumulate: addr 3 write 100 (acc_en=0), then 50 and 25 (acc_en=1) back-to-back, drain with out_ready=1 -> out_addr 3 shows 175, all other entries 0, drain lasts 8 cycles.
REQ-031 Saturation (ACC_W=32): addr 0 overwrite 0xFFFFFF, then 257 accumulate cycles of 0xFFFFFF -> entry 0xFFFFFFFF, sat_flag=1.
REQ-032 Backpressure: drain with out_ready toggling 1,0,0,1,... -> each entry emitted exactly once in order 0..7, data stable during stalls, entries read 0 afterwards.
REQ-033 Simultaneous: drain_start with in_valid addr 0 value 7 acc_en=0 same cycle -> first output out_addr 0, out_data 7; in_valid addr 2 during DRAIN -> entry 2 unchanged, drop_flag=1.
REQ-034 Reset mid-drain: assert rst after 3 handshakes -> next cycle out_valid 0, busy 0, flags 0; subsequent drain outputs all zeros.
